// File: rtl/impl_dp_ram_obi.sv
// impl_dp_ram_obi: byte-addressed dual-port RAM, OBI req/gnt/rvalid per port.
// Define DP_RAM_RANDOM_STALL_EN to withhold grants pseudo-randomly (LFSR).
module impl_dp_ram_obi_port #(
  parameter int          DW   = 32,
  parameter int          L    = 1,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [DW-1:0] mem_rd_i,
  output logic          gnt_o,
  output logic          acc_o,
  output logic          rvalid_o,
  output logic [DW-1:0] rdata_o
);
  localparam int CW = $clog2(L + 1);

  logic          rdy_q;
  logic [L-1:0]  vld_q;
  logic [DW-1:0] dat_q [L];
  logic [CW-1:0] cnt_q;

`ifdef DP_RAM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign gnt_o = rdy_q & ~lfsr_q[0];
`else
  assign gnt_o = rdy_q;
`endif

  assign acc_o = req_i & gnt_o;

  // stage 0 captures the pre-edge memory word; writes ack with zero data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_q <= 1'b0;
      vld_q <= '0;
      for (int i = 0; i < L; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      rdy_q    <= 1'b1;
      vld_q[0] <= acc_o;
      dat_q[0] <= (acc_o && !we_i) ? mem_rd_i : '0;
      for (int i = 1; i < L; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rvalid_o = vld_q[L-1];
  assign rdata_o  = dat_q[L-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(acc_o) - CW'(rvalid_o);
    end
  end

  a_cnt_bound: assert property (
    @(posedge clk_i) disable iff (!rst_ni) cnt_q <= CW'(L)
  );

endmodule

module impl_dp_ram_obi #(
  parameter int ADDR_WIDTH   = 22,
  parameter int A_DATA_WIDTH = 32,
  parameter int B_DATA_WIDTH = 32,
  parameter int RD_LATENCY   = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      a_req_i,
  output logic                      a_gnt_o,
  input  logic [ADDR_WIDTH-1:0]     a_addr_i,
  input  logic                      a_we_i,
  input  logic [A_DATA_WIDTH/8-1:0] a_be_i,
  input  logic [A_DATA_WIDTH-1:0]   a_wdata_i,
  output logic                      a_rvalid_o,
  output logic [A_DATA_WIDTH-1:0]   a_rdata_o,
  input  logic                      b_req_i,
  output logic                      b_gnt_o,
  input  logic [ADDR_WIDTH-1:0]     b_addr_i,
  input  logic                      b_we_i,
  input  logic [B_DATA_WIDTH/8-1:0] b_be_i,
  input  logic [B_DATA_WIDTH-1:0]   b_wdata_i,
  output logic                      b_rvalid_o,
  output logic [B_DATA_WIDTH-1:0]   b_rdata_o
);
  localparam int AB = A_DATA_WIDTH / 8;
  localparam int BB = B_DATA_WIDTH / 8;
  localparam int AO = $clog2(AB);
  localparam int BO = $clog2(BB);

  logic [7:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0]   a_base, b_base;
  logic [A_DATA_WIDTH-1:0] a_rd;
  logic [B_DATA_WIDTH-1:0] b_rd;
  logic                    a_acc, b_acc;
  logic                    unused_lsb;

  assign a_base = {a_addr_i[ADDR_WIDTH-1:AO], {AO{1'b0}}};
  assign b_base = {b_addr_i[ADDR_WIDTH-1:BO], {BO{1'b0}}};
  assign unused_lsb = ^{a_addr_i[AO-1:0], b_addr_i[BO-1:0]};

  always_comb begin
    a_rd = '0;
    for (int i = 0; i < AB; i++) begin
      a_rd[8*i +: 8] = mem[a_base + ADDR_WIDTH'(i)];
    end
  end

  always_comb begin
    b_rd = '0;
    for (int i = 0; i < BB; i++) begin
      b_rd[8*i +: 8] = mem[b_base + ADDR_WIDTH'(i)];
    end
  end

  // B is written last so it wins a same-byte collision
  always_ff @(posedge clk_i) begin
    if (a_acc && a_we_i) begin
      for (int i = 0; i < AB; i++) begin
        if (a_be_i[i]) begin
          mem[a_base + ADDR_WIDTH'(i)] <= a_wdata_i[8*i +: 8];
        end
      end
    end
    if (b_acc && b_we_i) begin
      for (int i = 0; i < BB; i++) begin
        if (b_be_i[i]) begin
          mem[b_base + ADDR_WIDTH'(i)] <= b_wdata_i[8*i +: 8];
        end
      end
    end
  end

  impl_dp_ram_obi_port #(
    .DW   (A_DATA_WIDTH),
    .L    (RD_LATENCY),
    .SEED (16'hACE1)
  ) u_port_a (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (a_req_i),
    .we_i     (a_we_i),
    .mem_rd_i (a_rd),
    .gnt_o    (a_gnt_o),
    .acc_o    (a_acc),
    .rvalid_o (a_rvalid_o),
    .rdata_o  (a_rdata_o)
  );

  impl_dp_ram_obi_port #(
    .DW   (B_DATA_WIDTH),
    .L    (RD_LATENCY),
    .SEED (16'h1D2C)
  ) u_port_b (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (b_req_i),
    .we_i     (b_we_i),
    .mem_rd_i (b_rd),
    .gnt_o    (b_gnt_o),
    .acc_o    (b_acc),
    .rvalid_o (b_rvalid_o),
    .rdata_o  (b_rdata_o)
  );

endmodule

// File: tb/tb_impl_dp_ram_obi.sv
// tb_impl_dp_ram_obi: directed vectors, corner sequences and random traffic
// for impl_dp_ram_obi, checked against a byte-array reference model.
module tb_impl_dp_ram_obi;
  localparam int AW  = 16;
  localparam int L   = 3;
  localparam int MSZ = 1024;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [15:0]  a_be = '0;
  logic [127:0] a_wdata = '0;
  logic         b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [3:0]   b_be = '0;
  logic [31:0]  b_wdata = '0;
  logic         a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [127:0] a_rdata;
  logic [31:0]  b_rdata;

  impl_dp_ram_obi #(
    .ADDR_WIDTH   (AW),
    .A_DATA_WIDTH (128),
    .B_DATA_WIDTH (32),
    .RD_LATENCY   (L)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .a_req_i    (a_req),
    .a_gnt_o    (a_gnt),
    .a_addr_i   (a_addr),
    .a_we_i     (a_we),
    .a_be_i     (a_be),
    .a_wdata_i  (a_wdata),
    .a_rvalid_o (a_rvalid),
    .a_rdata_o  (a_rdata),
    .b_req_i    (b_req),
    .b_gnt_o    (b_gnt),
    .b_addr_i   (b_addr),
    .b_we_i     (b_we),
    .b_be_i     (b_be),
    .b_wdata_i  (b_wdata),
    .b_rvalid_o (b_rvalid),
    .b_rdata_o  (b_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model: byte array plus queues of {due cycle, data}
  typedef struct {
    int           due;
    logic [127:0] d;
  } resp_t;

  resp_t        qa[$], qb[$];
  logic [7:0]   m [MSZ];
  logic [127:0] a_last = '0, b_last = '0;
  int           a_nresp = 0, b_nresp = 0;
  int           since_rst = 0;
  logic [127:0] rda, rdb;
  int           abase, bbase;
  bit           acc_a, acc_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      since_rst = 0;
      check("rst_a_rvalid", a_rvalid, 0);
      check("rst_b_rvalid", b_rvalid, 0);
      check("rst_a_rdata", a_rdata, 0);
      check("rst_b_rdata", b_rdata, 0);
      check("rst_a_gnt", a_gnt, 0);
      check("rst_b_gnt", b_gnt, 0);
    end else begin
      since_rst++;
      if (qa.size() > 0 && qa[0].due == cyc) begin
        check("a_rvalid", a_rvalid, 1);
        check("a_rdata", a_rdata, qa[0].d);
        void'(qa.pop_front());
      end else begin
        check("a_rvalid_idle", a_rvalid, 0);
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        check("b_rvalid", b_rvalid, 1);
        check("b_rdata", b_rdata, qb[0].d);
        void'(qb.pop_front());
      end else begin
        check("b_rvalid_idle", b_rvalid, 0);
      end
      if (a_rvalid) begin a_last = a_rdata; a_nresp++; end
      if (b_rvalid) begin b_last = 128'(b_rdata); b_nresp++; end
`ifndef DP_RAM_RANDOM_STALL_EN
      check("a_gnt", a_gnt, since_rst >= 2);
      check("b_gnt", b_gnt, since_rst >= 2);
`endif
      acc_a = a_req && a_gnt;
      acc_b = b_req && b_gnt;
      abase = int'(a_addr) / 16 * 16;
      bbase = int'(b_addr) / 4 * 4;
      rda = '0;
      rdb = '0;
      if (acc_a && !a_we)
        for (int i = 0; i < 16; i++) rda[8*i +: 8] = m[(abase + i) % MSZ];
      if (acc_b && !b_we)
        for (int i = 0; i < 4; i++) rdb[8*i +: 8] = m[(bbase + i) % MSZ];
      if (acc_a) qa.push_back('{cyc + L, rda});
      if (acc_b) qb.push_back('{cyc + L, rdb});
      if (acc_a && a_we)
        for (int i = 0; i < 16; i++)
          if (a_be[i]) m[(abase + i) % MSZ] = a_wdata[8*i +: 8];
      if (acc_b && b_we)
        for (int i = 0; i < 4; i++)
          if (b_be[i]) m[(bbase + i) % MSZ] = b_wdata[8*i +: 8];
    end
  end

  // called and returns at posedge+1; holds each req until granted
  task automatic issue(
    input bit da, input bit awe, input int aad, input logic [15:0] abe,
    input logic [127:0] awd,
    input bit db, input bit bwe, input int bad, input logic [3:0] bbe,
    input logic [31:0] bwd);
    bit ga, gb;
    a_req = da; a_we = awe; a_addr = AW'(aad); a_be = abe; a_wdata = awd;
    b_req = db; b_we = bwe; b_addr = AW'(bad); b_be = bbe; b_wdata = bwd;
    for (int t = 0; t < 100 && (a_req || b_req); t++) begin
      @(negedge clk);
      ga = a_gnt;
      gb = b_gnt;
      @(posedge clk);
      #1;
      if (ga) a_req = 1'b0;
      if (gb) b_req = 1'b0;
    end
    if (a_req || b_req) begin
      check("grant_timeout", 1, 0);
      a_req = 1'b0;
      b_req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_op(input bit we, input int ad, input logic [15:0] be,
                      input logic [127:0] wd);
    issue(1, we, ad, be, wd, 0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic b_op(input bit we, input int ad, input logic [3:0] be,
                      input logic [31:0] wd);
    issue(0, 0, 0, 16'h0, 128'h0, 1, we, ad, be, wd);
  endtask

  typedef struct {
    bit           pb;
    bit           we;
    int           addr;
    logic [15:0]  be;
    logic [127:0] wd;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [12];
  int   n0, m0;

  initial begin
    vecs[0]  = '{1, 1, 'h100, 16'h5, 128'hDEADBEEF, 128'h0};
    vecs[1]  = '{1, 0, 'h100, 16'h0, 128'h0, 128'h00AD00EF};
    vecs[2]  = '{0, 1, 'h40, 16'hFFFF,
                 128'h0F0E0D0C0B0A09080706050403020100, 128'h0};
    vecs[3]  = '{0, 0, 'h44, 16'h0, 128'h0,
                 128'h0F0E0D0C0B0A09080706050403020100};
    vecs[4]  = '{1, 0, 'h48, 16'h0, 128'h0, 128'h0B0A0908};
    vecs[5]  = '{1, 1, 'h104, 16'h0, 128'hFFFFFFFF, 128'h0};
    vecs[6]  = '{1, 0, 'h104, 16'h0, 128'h0, 128'h0};
    vecs[7]  = '{0, 1, 'h100, 16'h2, 128'h5500, 128'h0};
    vecs[8]  = '{1, 0, 'h100, 16'h0, 128'h0, 128'h00AD55EF};
    vecs[9]  = '{0, 0, 'h10C, 16'h0, 128'h0, 128'h00AD55EF};
    vecs[10] = '{1, 1, 'h3FC, 16'hF, 128'hCAFEF00D, 128'h0};
    vecs[11] = '{0, 0, 'h3F0, 16'h0, 128'h0, {32'hCAFEF00D, 96'h0}};

    for (int i = 0; i < MSZ; i++) m[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < MSZ; i += 4) b_op(1, i, 4'hF, 32'h0);
    idle(L + 1);

    foreach (vecs[i]) begin
      n0 = vecs[i].pb ? b_nresp : a_nresp;
      if (vecs[i].pb)
        b_op(vecs[i].we, vecs[i].addr, vecs[i].be[3:0], vecs[i].wd[31:0]);
      else
        a_op(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wd);
      idle(L + 1);
      check($sformatf("vec%0d_nresp", i),
            (vecs[i].pb ? b_nresp : a_nresp) - n0, 1);
      check($sformatf("vec%0d_data", i),
            vecs[i].pb ? b_last : a_last, vecs[i].exp);
    end

    // four back-to-back A reads
    for (int i = 0; i < 4; i++) b_op(1, 'h10 * i, 4'hF, 32'h01010101 * (i + 1));
    idle(L + 1);
    n0 = a_nresp;
    for (int i = 0; i < 4; i++) a_op(0, 'h10 * i, 16'h0, 128'h0);
    idle(L + 2);
    check("b2b_count", a_nresp - n0, 4);
    check("b2b_last", a_last, 128'h04040404);

    // same-edge read vs write, then same-byte write collision
    issue(1, 0, 'h200, 16'h0, 128'h0, 1, 1, 'h200, 4'hF, 32'h11223344);
    idle(L + 1);
    check("same_edge_old", a_last, 128'h0);
    a_op(0, 'h200, 16'h0, 128'h0);
    idle(L + 1);
    check("same_edge_new", a_last, 128'h11223344);
    issue(1, 1, 'h300, 16'h1, 128'hAA, 1, 1, 'h300, 4'h1, 32'hBB);
    b_op(0, 'h300, 4'h0, 32'h0);
    idle(L + 1);
    check("collide_b_wins", b_last, 128'hBB);

    // reset with reads in flight
    issue(1, 0, 'h40, 16'h0, 128'h0, 1, 0, 'h100, 4'h0, 32'h0);
    a_op(0, 'h44, 16'h0, 128'h0);
    n0 = a_nresp;
    m0 = b_nresp;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(L + 3);
    check("rst_drop_a", a_nresp - n0, 0);
    check("rst_drop_b", b_nresp - m0, 0);
    b_op(0, 'h100, 4'h0, 32'h0);
    idle(L + 1);
    check("rst_mem_kept", b_last, 128'h00AD55EF);

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      a_req   = 1'($urandom_range(0, 1));
      a_we    = ($urandom_range(0, 3) == 0);
      a_addr  = AW'($urandom_range(0, 63) * 16 + $urandom_range(0, 15));
      a_be    = 16'($urandom);
      a_wdata = {$urandom, $urandom, $urandom, $urandom};
      b_req   = 1'($urandom_range(0, 1));
      b_we    = ($urandom_range(0, 1) == 0);
      b_addr  = AW'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
      b_be    = 4'($urandom);
      b_wdata = $urandom;
      @(posedge clk);
      #1;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    idle(L + 2);
    check("a_drained", qa.size(), 0);
    check("b_drained", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
